fir_seq_div: RTL and testbench
==============================

Name: fir_seq_div

Overview:
- Sequential unsigned restoring divider for the FIR datapath: gain normalisation and averaging of accumulator outputs.
- Computes one quotient bit per clock using a ripple chain of full-subtractor cells. This is the subtract-direction counterpart of the existing full-adder cell.
- Sits after the accumulator.
- Valid/ready handshake on both input and output.

Parameters:
- DATA_W, 16: width of dividend, divisor, quotient and remainder (legal range 2..32).
- CNT_W, 5: width of the iteration counter; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- dividend  in  DATA_W  unsigned numerator.
- divisor  in  DATA_W  unsigned denominator.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- quotient  out  DATA_W  unsigned quotient.
- remainder  out  DATA_W  unsigned remainder.
- div_by_zero  out  1  result came from a zero divisor.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. Reset asserts immediately and deasserts synchronously to clk.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - Internal counter, partial remainder and operand registers = 0.
- States and transitions:
  - IDLE: in_ready=1. On edge with in_valid&in_ready, latch dividend/divisor.
    - divisor==0 -> DONE.
    - Otherwise -> CALC, counter=DATA_W-1, partial remainder=0.
  - CALC: in_ready=0, out_valid=0. One iteration per edge; after the iteration with counter==0 -> DONE.
  - DONE: out_valid=1, outputs stable. On edge with out_ready -> IDLE. With out_ready low, stay; quotient, remainder and div_by_zero must not change.
- Iteration (restoring):
  - trial = {rem[DATA_W-1:0], dividend_msb}, DATA_W+1 bits.
  - diff = trial - {1'b0, divisor} through the subtractor chain; borrow = final borrow-out.
  - If borrow==0: rem=diff, shift quotient bit 1. Otherwise rem=trial, shift 0.
  - Dividend register shifts left by one each iteration.
- Latency:
  - Accept on edge E0; iterations on E1..E_DATA_W; out_valid visible after E_DATA_W. That is DATA_W cycles, so 16 by default.
  - Divide-by-zero: out_valid after E1.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
- div_by_zero is cleared when a new operation is accepted.
- No same-cycle turnaround: in_ready reasserts the cycle after the output handshake. Normal throughput is one operation per DATA_W+2 cycles.
- in_valid/operand changes during CALC/DONE are ignored.
- Reset mid-CALC or mid-DONE: immediate return to IDLE with reset values. The partial result is discarded and no out_valid pulse is produced.
- No signed support. Quotient is never wider than DATA_W.

Decomposition:
- Shared package/header fir_pkg:
  - State encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - Default DATA_W.
- Sub-module fs: 1-bit full subtractor (a, b, bin -> diff, bout), diff=a^b^bin, bout=(~a&b)|(~a&bin)|(b&bin).
  - fir_seq_div instantiates DATA_W+1 fs cells in a generate-loop ripple chain, with bin of bit 0 tied to 0.

Test Plan:
- 100 / 7, out_ready=1 -> out_valid exactly 16 cycles after accept; quotient=14, remainder=2, div_by_zero=0; in_ready high the following cycle.
- 0xFFFF / 1, then 3 / 0xFFFF -> results 0xFFFF r 0, then 0 r 3. The second operation is accepted only after the first result handshake.
- 5 / 0 -> out_valid 1 cycle after accept; quotient=0xFFFF, remainder=5, div_by_zero=1. The next op, 9 / 3, returns 3 r 0 with div_by_zero=0.
- 1000 / 33 with out_ready held low for 5 cycles after out_valid -> outputs held at 30 r 10 throughout; in_ready stays 0 until the out_ready edge.
- Toggle in_valid with changing operands during CALC of 50 / 6 -> result unaffected, 8 r 2.
- Assert rst_n low at cycle 8 of CALC of 200 / 9 -> all outputs immediately reset values, in_ready=1. A fresh 200 / 9 returns 22 r 2.

Source files
------------

// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared encodings and defaults for the FIR datapath blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fs.sv
// ============================================================================
// Module   : fs
// Purpose  : One-bit full subtractor, a - b - bin, with borrow out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

`default_nettype wire

// File: rtl/fir_seq_div.sv
// ============================================================================
// Module   : fir_seq_div
// Purpose  : Sequential unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_seq_div
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dvs;

    logic [DATA_W:0]   w_trial;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W+1:0] w_borrow;
    logic              w_qbit;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_quo_next;

    assign w_trial     = {r_rem, r_dvd[DATA_W-1]};
    assign w_sub       = {1'b0, r_dvs};
    assign w_borrow[0] = 1'b0;

    generate
        for (genvar i = 0; i <= DATA_W; i++) begin : g_fs
            fs u_fs (
                .a    (w_trial[i]),
                .b    (w_sub[i]),
                .bin  (w_borrow[i]),
                .diff (w_diff[i]),
                .bout (w_borrow[i+1])
            );
        end
    endgenerate

    // The top diff bit is always zero when there is no borrow, so including it
    // leaves the result unchanged while keeping every cell output in use.
    assign w_qbit     = ~w_borrow[DATA_W+1] & ~w_diff[DATA_W];
    assign w_rem_next = w_qbit ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
    // The dividend register doubles as the quotient shift register.
    assign w_quo_next = {r_dvd[DATA_W-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_dvd       <= dividend;
                        r_dvs       <= divisor;
                        r_rem       <= '0;
                        r_cnt       <= C_CNT_LAST;
                        div_by_zero <= 1'b0;
                        in_ready    <= 1'b0;
                        r_state     <= (divisor == '0) ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_quo_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        quotient  <= w_quo_next;
                        remainder <= w_rem_next;
                        out_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A zero divisor arrives here with out_valid still low and
                    // publishes its result one cycle after acceptance.
                    if (!out_valid) begin
                        quotient    <= '1;
                        remainder   <= r_dvd;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_seq_div.sv
// ============================================================================
// Module   : tb_fir_seq_div
// Purpose  : Randomised self-checking bench for fir_seq_div against / and %.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_seq_div;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    fir_seq_div #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic start_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input int stall, input bit scramble);
        logic [DATA_W-1:0] exp_q;
        logic [DATA_W-1:0] exp_r;
        int                exp_lat;
        int                cyc = 0;
        exp_q   = (b == 0) ? {DATA_W{1'b1}} : a / b;
        exp_r   = (b == 0) ? a : a % b;
        exp_lat = (b == 0) ? 1 : DATA_W;
        out_ready = (stall == 0);
        while (!out_valid && cyc < 100) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (scramble) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = DATA_W'($urandom);
                divisor  = DATA_W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", cyc, exp_lat);
        check("quotient", {16'd0, quotient}, {16'd0, exp_q});
        check("remainder", {16'd0, remainder}, {16'd0, exp_r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, (b == 0)});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_quotient", {16'd0, quotient}, {16'd0, exp_q});
            check("hold_remainder", {16'd0, remainder}, {16'd0, exp_r});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input int stall, input bit scramble);
        start_op(a, b);
        finish_op(a, b, stall, scramble);
    endtask

    initial begin
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'd100, 16'd7, 0, 1'b0);
        run_op(16'hFFFF, 16'd1, 0, 1'b0);
        run_op(16'd3, 16'hFFFF, 0, 1'b0);
        run_op(16'd5, 16'd0, 0, 1'b0);
        run_op(16'd9, 16'd3, 0, 1'b0);
        run_op(16'd1000, 16'd33, 5, 1'b0);
        run_op(16'd50, 16'd6, 0, 1'b1);

        // Asynchronous reset in the middle of a calculation.
        start_op(16'd200, 16'd9);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", {16'd0, quotient}, 32'd0);
        check("midrst_remainder", {16'd0, remainder}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'd200, 16'd9, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            ra = DATA_W'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = DATA_W'($urandom_range(1, 15));
                2:       rb = 16'd1;
                default: rb = DATA_W'($urandom);
            endcase
            run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
